// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
//  - tt_state_e : sweep FSM state encoding
//  - TT_ROWS    : number of input rows for a 3-input block
//  - tt_row_bit : maps a row index to its bit position in the code (row 000 -> MSB)
package tt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } tt_state_e;

  localparam int         TT_ROWS     = 8;
  localparam logic [2:0] TT_LAST_ROW = 3'(TT_ROWS - 1);

  // Row 000 lands in bit 7 so the code reads like a truth table top-to-bottom.
  function automatic logic [2:0] tt_row_bit(input logic [2:0] row);
    return 3'd7 - row;
  endfunction

endpackage

// File: rtl/tt_sync.sv
// Reset-clearing synchroniser chain for the (possibly asynchronous) output
// of the block under test.
//  clk     in  clock
//  rst_n   in  synchronous active-low reset, clears every stage
//  i_async in  raw input
//  o_sync  out synchronised copy, STAGES cycles late
module tt_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw input through the synchroniser flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives rows 000..111 into a 3-input block, waits a
// settle time per row, samples the synchronised output and assembles an
// 8-bit code which is compared against an expected code.
//  clk           in   clock, rising edge
//  rst_n         in   synchronous active-low reset
//  start         in   begin a sweep (only honoured in IDLE)
//  abort         in   cancel a running sweep (wins over start)
//  expected      in   expected code, latched when start is accepted
//  drv_in        out  {in1,in2,in3} to the block under test
//  dut_out       in   block output, may be asynchronous
//  busy          out  sweep in progress
//  done          out  one-cycle completion pulse
//  code          out  last completed code, MSB = row 000
//  match         out  code == latched expected
//  mismatch_mask out  code ^ latched expected
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic [2:0] drv_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       match,
  output logic [7:0] mismatch_mask
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  tt_state_e  r_state;
  logic [2:0] r_row;
  logic [7:0] r_settle_cnt;
  logic [7:0] r_shadow;
  logic [7:0] r_expected;
  logic       w_sync;

  tt_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (dut_out),
    .o_sync  (w_sync)
  );

  // Sweep FSM with row/settle counters, shadow code and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_row         <= 3'd0;
      r_settle_cnt  <= 8'd0;
      r_shadow      <= 8'd0;
      r_expected    <= 8'd0;
      drv_in        <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      code          <= 8'd0;
      match         <= 1'b0;
      mismatch_mask <= 8'd0;
    end else begin
      done <= 1'b0;
      if ((r_state != IDLE) && abort) begin
        // Abandon the sweep; results from the previous sweep are kept.
        r_state <= IDLE;
        drv_in  <= 3'd0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            drv_in <= 3'd0;
            if (start) begin
              r_expected <= expected;
              r_row      <= 3'd0;
              r_shadow   <= 8'd0;
              busy       <= 1'b1;
              r_state    <= DRIVE;
            end
          end
          DRIVE: begin
            drv_in       <= r_row;
            r_settle_cnt <= 8'd0;
            r_state      <= SETTLE;
          end
          SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state <= SAMPLE;
            end else begin
              r_settle_cnt <= r_settle_cnt + 8'd1;
            end
          end
          SAMPLE: begin
            r_shadow[tt_row_bit(r_row)] <= w_sync;
            // Explicit terminal test so the 3-bit row never wraps within a sweep.
            if (r_row == TT_LAST_ROW) begin
              r_state <= DONE;
            end else begin
              r_row   <= r_row + 3'd1;
              r_state <= DRIVE;
            end
          end
          DONE: begin
            code          <= r_shadow;
            match         <= (r_shadow == r_expected);
            mismatch_mask <= r_shadow ^ r_expected;
            done          <= 1'b1;
            busy          <= 1'b0;
            drv_in        <= 3'd0;
            r_state       <= IDLE;
          end
          default: begin
            drv_in  <= 3'd0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: table-driven sweeps with a
// scoreboard, plus hand-written sequences for restart, reset and abort cases.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [2:0] drv_in;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] code;
  logic       match;
  logic [7:0] mismatch_mask;

  logic [7:0] model_code;
  logic [1:0] tie_mode;   // 0: model, 1: tied high, 2: tied low

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] func;
    logic [1:0] tie;
    logic [7:0] exp_in;
    logic [7:0] code;
    logic       match;
    logic [7:0] mask;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    logic       match;
    logic [7:0] mask;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[5];

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // Block under test: row r answers with bit (7-r) of model_code.
  assign dut_out = (tie_mode == 2'd0) ? model_code[3'd7 - drv_in] : (tie_mode == 2'd1);

  truth_table_sweeper #(
    .SETTLE_CYCLES (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .expected      (expected),
    .drv_in        (drv_in),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .code          (code),
    .match         (match),
    .mismatch_mask (mismatch_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic wait_drv(input logic [2:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (drv_in == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One full sweep: push expectation, pulse start, follow drv_in, compare on done.
  task automatic run_sweep(input logic [7:0] exp_in, input sb_t e, input string tag);
    int         accept;
    int         steps;
    int         bad;
    bit         seen;
    logic [2:0] last;
    sb_t        got;
    sb_q.push_back(e);
    @(negedge clk);
    start    = 1'b1;
    expected = exp_in;
    accept   = edge_cnt + 1;
    @(negedge clk);
    start    = 1'b0;
    expected = ~exp_in;   // must not disturb the running sweep
    check({tag, "_busy"}, 32'(busy), 32'd1);
    last  = drv_in;
    steps = 0;
    bad   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (drv_in != last) begin
        if (drv_in != last + 3'd1) bad++;
        steps++;
        last = drv_in;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(edge_cnt - accept), 32'd49);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_drv_steps"}, 32'(steps), 32'd7);
      check({tag, "_drv_order"}, 32'(bad), 32'd0);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        got = sb_q.pop_front();
        check({tag, "_code"}, 32'(code), 32'(got.code));
        check({tag, "_match"}, 32'(match), 32'(got.match));
        check({tag, "_mask"}, 32'(mismatch_mask), 32'(got.mask));
      end
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    bit  ok;
    int  base;
    int  accept;
    int  off;
    int  done_off;
    sb_t e;

    vecs[0] = '{8'h4C, 2'd0, 8'h4C, 8'h4C, 1'b1, 8'h00};
    vecs[1] = '{8'h4C, 2'd0, 8'h4D, 8'h4C, 1'b0, 8'h01};
    vecs[2] = '{8'h00, 2'd1, 8'hFF, 8'hFF, 1'b1, 8'h00};
    vecs[3] = '{8'h00, 2'd2, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{8'hA5, 2'd0, 8'h5A, 8'hA5, 1'b0, 8'hFF};

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    expected   = 8'h00;
    model_code = 8'h00;
    tie_mode   = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_drv", 32'(drv_in), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_mask", 32'(mismatch_mask), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven sweeps.
    for (int v = 0; v < 5; v++) begin
      model_code = vecs[v].func;
      tie_mode   = vecs[v].tie;
      e = '{vecs[v].code, vecs[v].match, vecs[v].mask};
      run_sweep(vecs[v].exp_in, e, $sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
    end

    // Start re-pulsed in SETTLE of row 2 and in the DONE cycle: one sweep only.
    model_code = 8'h4C;
    tie_mode   = 2'd0;
    @(negedge clk);
    start    = 1'b1;
    expected = 8'h4C;
    accept   = edge_cnt + 1;
    base     = done_cnt;
    done_off = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      off   = edge_cnt - accept;
      start = (off == 14) || (off == 48);
      if (done && (done_off < 0)) done_off = off;
    end
    start = 1'b0;
    check("restart_done_count", 32'(done_cnt - base), 32'd1);
    check("restart_done_edge", 32'(done_off), 32'd49);
    check("restart_busy_after", 32'(busy), 32'd0);
    check("restart_code", 32'(code), 32'h4C);

    // Reset for one edge mid-sweep while drv_in = 3'b011.
    @(negedge clk);
    start    = 1'b1;
    expected = 8'h4C;
    @(negedge clk);
    start = 1'b0;
    wait_drv(3'd3, ok);
    check("reset_reach_row3", 32'(ok), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_drv", 32'(drv_in), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    check("midrst_match", 32'(match), 32'd0);
    check("midrst_mask", 32'(mismatch_mask), 32'd0);
    base = done_cnt;
    repeat (60) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    e = '{8'h4C, 1'b1, 8'h00};
    run_sweep(8'h4C, e, "post_reset");
    repeat (2) @(negedge clk);

    // Abort at row 5: results of the previous sweep must survive.
    @(negedge clk);
    start    = 1'b1;
    expected = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_drv(3'd5, ok);
    check("abort_reach_row5", 32'(ok), 32'd1);
    abort = 1'b1;
    base  = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    check("abort_drv", 32'(drv_in), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_code", 32'(code), 32'h4C);
    check("abort_match", 32'(match), 32'd1);
    check("abort_mask", 32'(mismatch_mask), 32'd0);
    check("abort_drv_idle", 32'(drv_in), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
